// File: rtl/regfile_sb_if.sv
// Register file bus: decode-side reads and issue, writeback-side writes,
// scoreboard status back to decode.
//   master : pipeline side (drives indices, write data, issue)
//   slave  : register file (drives read data and pending status)
interface regfile_sb_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
);
    logic [ADDR_W-1:0] src_reg1;
    logic [ADDR_W-1:0] src_reg2;
    logic [DATA_W-1:0] src_data1;
    logic [DATA_W-1:0] src_data2;
    logic [ADDR_W-1:0] dst_reg;
    logic              write_reg;
    logic [DATA_W-1:0] dst_data;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_reg;
    logic              pending1;
    logic              pending2;
    logic [ADDR_W:0]   pending_cnt;

    modport master (
        output src_reg1, src_reg2, dst_reg, write_reg, dst_data,
               issue_valid, issue_reg,
        input  src_data1, src_data2, pending1, pending2, pending_cnt
    );

    modport slave (
        input  src_reg1, src_reg2, dst_reg, write_reg, dst_data,
               issue_valid, issue_reg,
        output src_data1, src_data2, pending1, pending2, pending_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised register file with two combinational read ports, one write
// port and an integrated per-register RAW scoreboard.
//   clk  : clock, all state updates on rising edge
//   rst  : synchronous active-high reset (clears registers and scoreboard)
//   bus  : regfile_sb_if.slave
//            src_reg1/2 -> src_data1/2, pending1/2 (combinational)
//            dst_reg/write_reg/dst_data : writeback port
//            issue_valid/issue_reg      : marks a destination in flight
//            pending_cnt                : registered count of pending regs
module regfile_sb #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    localparam int unsigned NREGS = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] r_mem [NREGS];
    logic [NREGS-1:0]  r_pending;
    logic [CNT_W-1:0]  r_pending_cnt;

    logic [NREGS-1:0]  w_pending_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_wr_en;
    logic              w_hit1;
    logic              w_hit2;

    // Writes to the hardwired zero register are dropped
    assign w_wr_en = bus.write_reg &&
                     !(ZERO_REG && (bus.dst_reg == ADDR_W'(0)));

    // Scoreboard next state and its popcount; a new issue wins over a
    // retiring write to the same register
    always_comb begin
        w_pending_nxt = '0;
        w_cnt_nxt     = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_pending_nxt[i] =
                (bus.issue_valid && (bus.issue_reg == ADDR_W'(i))) ||
                (r_pending[i] && !(bus.write_reg && (bus.dst_reg == ADDR_W'(i))));
        end
        if (ZERO_REG) begin
            w_pending_nxt[0] = 1'b0;
        end
        for (int i = 0; i < NREGS; i++) begin
            w_cnt_nxt = w_cnt_nxt + CNT_W'(w_pending_nxt[i]);
        end
    end

    // Register array
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[bus.dst_reg] <= bus.dst_data;
        end
    end

    // Scoreboard state and count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending     <= '0;
            r_pending_cnt <= '0;
        end else begin
            r_pending     <= w_pending_nxt;
            r_pending_cnt <= w_cnt_nxt;
        end
    end

    // Same-cycle writeback match per read port
    assign w_hit1 = bus.write_reg && (bus.dst_reg == bus.src_reg1);
    assign w_hit2 = bus.write_reg && (bus.dst_reg == bus.src_reg2);

    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic              hit
    );
        if (ZERO_REG && (addr == ADDR_W'(0))) begin
            return '0;
        end else if (BYPASS && hit) begin
            return bus.dst_data;
        end else begin
            return r_mem[addr];
        end
    endfunction

    assign bus.src_data1   = read_port(bus.src_reg1, w_hit1);
    assign bus.src_data2   = read_port(bus.src_reg2, w_hit2);

    // With bypass, a same-cycle writeback resolves the hazard
    assign bus.pending1    = r_pending[bus.src_reg1] && !(BYPASS && w_hit1);
    assign bus.pending2    = r_pending[bus.src_reg2] && !(BYPASS && w_hit2);
    assign bus.pending_cnt = r_pending_cnt;
endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 4;

    logic clk = 1'b0;
    logic rst;
    logic [ADDR_W-1:0] src_reg1, src_reg2, dst_reg, issue_reg;
    logic              write_reg, issue_valid;
    logic [DATA_W-1:0] dst_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // DUT A: bypass + zero register; DUT B: neither
    regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_a ();
    regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_b ();

    assign bus_a.src_reg1 = src_reg1;    assign bus_b.src_reg1 = src_reg1;
    assign bus_a.src_reg2 = src_reg2;    assign bus_b.src_reg2 = src_reg2;
    assign bus_a.dst_reg = dst_reg;      assign bus_b.dst_reg = dst_reg;
    assign bus_a.write_reg = write_reg;  assign bus_b.write_reg = write_reg;
    assign bus_a.dst_data = dst_data;    assign bus_b.dst_data = dst_data;
    assign bus_a.issue_valid = issue_valid; assign bus_b.issue_valid = issue_valid;
    assign bus_a.issue_reg = issue_reg;  assign bus_b.issue_reg = issue_reg;

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b1), .ZERO_REG(1'b1))
        u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b0), .ZERO_REG(1'b0))
        u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct {
        logic        rst;
        logic        wr;
        logic [3:0]  dst;
        logic [15:0] data;
        logic        iv;
        logic [3:0]  ireg;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [15:0] e_d1;
        logic [15:0] e_d2;
        logic        e_p1;
        logic        e_p2;
        logic [4:0]  e_cnt;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic wr, input logic [3:0] dst,
                         input logic [15:0] data, input logic iv, input logic [3:0] ireg,
                         input logic [3:0] s1, input logic [3:0] s2);
        rst = r; write_reg = wr; dst_reg = dst; dst_data = data;
        issue_valid = iv; issue_reg = ireg; src_reg1 = s1; src_reg2 = s2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst wr dst data iv ireg s1 s2 | d1 d2 p1 p2 cnt
        vecs[0]  = '{0,0,0,16'h0000,0,0, 0,15, 16'h0000,16'h0000,0,0,0};
        vecs[1]  = '{0,0,0,16'h0000,0,0, 7, 8, 16'h0000,16'h0000,0,0,0};
        vecs[2]  = '{0,1,3,16'hBEEF,0,0, 3, 3, 16'hBEEF,16'hBEEF,0,0,0};
        vecs[3]  = '{0,0,0,16'h0000,0,0, 3, 4, 16'hBEEF,16'h0000,0,0,0};
        vecs[4]  = '{0,1,0,16'hFFFF,1,0, 0, 0, 16'h0000,16'h0000,0,0,0};
        vecs[5]  = '{0,0,0,16'h0000,1,5, 0, 3, 16'h0000,16'hBEEF,0,0,0};
        vecs[6]  = '{0,0,0,16'h0000,1,7, 5, 7, 16'h0000,16'h0000,1,0,1};
        vecs[7]  = '{0,1,5,16'h1234,0,0, 5, 7, 16'h1234,16'h0000,0,1,2};
        vecs[8]  = '{0,0,0,16'h0000,0,0, 5, 7, 16'h1234,16'h0000,0,1,1};
        vecs[9]  = '{0,0,0,16'h0000,1,9, 9, 9, 16'h0000,16'h0000,0,0,1};
        vecs[10] = '{0,1,9,16'hABCD,1,9, 9, 2, 16'hABCD,16'h0000,0,0,2};
        vecs[11] = '{0,0,0,16'h0000,0,0, 9, 7, 16'hABCD,16'h0000,1,1,2};
        vecs[12] = '{0,1,7,16'h7777,1,2, 2, 7, 16'h0000,16'h7777,0,0,2};
        vecs[13] = '{0,1,6,16'hAAAA,1,4, 6, 2, 16'hAAAA,16'h0000,0,1,2};
        vecs[14] = '{1,1,6,16'h5555,1,8, 6, 4, 16'h5555,16'h0000,0,1,3};
        vecs[15] = '{0,0,0,16'h0000,0,0, 6, 8, 16'h0000,16'h0000,0,0,0};
        vecs[16] = '{0,0,0,16'h0000,0,0, 9, 3, 16'h0000,16'h0000,0,0,0};

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Post-reset sweep of every register on both ports
        for (int r = 0; r < 16; r++) begin
            drive(0, 0, 0, 0, 0, 0, 4'(r), 4'(15 - r));
            #1;
            chk($sformatf("reset_d1[%0d]", r), 32'(bus_a.src_data1), 32'h0);
            chk($sformatf("reset_d2[%0d]", r), 32'(bus_a.src_data2), 32'h0);
            chk($sformatf("reset_p[%0d]", r), {30'h0, bus_a.pending1, bus_a.pending2}, 32'h0);
        end
        chk("reset_cnt", 32'(bus_a.pending_cnt), 32'h0);

        // Directed table on the bypass/zero-register configuration
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].rst, vecs[i].wr, vecs[i].dst, vecs[i].data,
                  vecs[i].iv, vecs[i].ireg, vecs[i].s1, vecs[i].s2);
            #1;
            chk($sformatf("v%0d_d1", i), 32'(bus_a.src_data1), 32'(vecs[i].e_d1));
            chk($sformatf("v%0d_d2", i), 32'(bus_a.src_data2), 32'(vecs[i].e_d2));
            chk($sformatf("v%0d_p1", i), 32'(bus_a.pending1), 32'(vecs[i].e_p1));
            chk($sformatf("v%0d_p2", i), 32'(bus_a.pending2), 32'(vecs[i].e_p2));
            chk($sformatf("v%0d_cnt", i), 32'(bus_a.pending_cnt), 32'(vecs[i].e_cnt));
            step();
        end

        // Fill the scoreboard to its maximum (r0 can never be pending)
        for (int r = 1; r < 16; r++) begin
            drive(0, 0, 0, 0, 1, 4'(r), 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 1, 0, 15, 1);
        #1;
        chk("full_cnt", 32'(bus_a.pending_cnt), 32'd15);
        chk("full_p1", 32'(bus_a.pending1), 32'd1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("full_cnt_r0_issue", 32'(bus_a.pending_cnt), 32'd15);
        chk("full_cnt_b", 32'(bus_b.pending_cnt), 32'd16);
        for (int r = 0; r < 16; r++) begin
            drive(0, 1, 4'(r), 16'(r), 0, 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 14, 0);
        #1;
        chk("drain_cnt", 32'(bus_a.pending_cnt), 32'd0);
        chk("drain_d1", 32'(bus_a.src_data1), 32'd14);

        // Non-bypass, non-zero-register configuration
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 1, 3, 16'hBEEF, 0, 0, 3, 0);
        #1;
        chk("b_nobypass_same", 32'(bus_b.src_data1), 32'h0000);
        chk("a_bypass_same", 32'(bus_a.src_data1), 32'hBEEF);
        step();
        drive(0, 1, 0, 16'hFFFF, 0, 0, 3, 0);
        #1;
        chk("b_nobypass_next", 32'(bus_b.src_data1), 32'hBEEF);
        step();
        drive(0, 0, 0, 0, 1, 0, 3, 0);
        #1;
        chk("b_r0_stored", 32'(bus_b.src_data2), 32'hFFFF);
        chk("a_r0_zero", 32'(bus_a.src_data2), 32'h0000);
        step();
        drive(0, 1, 0, 16'h1111, 0, 0, 3, 0);
        #1;
        chk("b_r0_cnt", 32'(bus_b.pending_cnt), 32'd1);
        chk("a_r0_cnt", 32'(bus_a.pending_cnt), 32'd0);
        chk("b_p2_nobypass", 32'(bus_b.pending2), 32'd1);
        chk("b_d2_nobypass", 32'(bus_b.src_data2), 32'hFFFF);
        step();
        drive(0, 0, 0, 0, 0, 0, 3, 0);
        #1;
        chk("b_cnt_cleared", 32'(bus_b.pending_cnt), 32'd0);
        chk("b_r0_new", 32'(bus_b.src_data2), 32'h1111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
